// File: rtl/ncl_dr_tx_pkg.sv
// rtl/ncl_dr_tx_pkg.sv - shared NCL dual-rail types and encoding helper
//
// Purpose : transmitter state encoding and the single-rail to dual-rail bit
//           encoder, shared with the NCL receive-side bridge.
// Contents: state_e    - S_NULL / S_DATA / S_RFD / S_ERR
//           DR_NULL    - {rail1,rail0} spacer value
//           dr_encode  - one data bit -> {rail1, rail0}
package ncl_dr_tx_pkg;

  typedef enum logic [1:0] {
    S_NULL = 2'd0,
    S_DATA = 2'd1,
    S_RFD  = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] DR_NULL = 2'b00;

  // 1 -> 10, 0 -> 01. The illegal 11 code is never produced.
  function automatic logic [1:0] dr_encode(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ncl_dr_tx_if.sv
// rtl/ncl_dr_tx_if.sv - host word handshake plus NCL dual-rail link
//
// Purpose : bundles the valid/ready word input and the NCL side (rails, ki).
// Signals : in_valid, in_ready, in_data[WIDTH] - single-rail word handshake
//           rail1, rail0 [WIDTH]               - dual-rail wavefront to the NCL fabric
//           ki                                 - completion from the NCL receiver
// Modports: slave  - the transmitter
//           master - host plus NCL receiver environment
interface ncl_dr_tx_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ki;
  logic [WIDTH-1:0] rail1;
  logic [WIDTH-1:0] rail0;

  modport slave (
    input  in_valid,
    input  in_data,
    input  ki,
    output in_ready,
    output rail1,
    output rail0
  );

  modport master (
    output in_valid,
    output in_data,
    output ki,
    input  in_ready,
    input  rail1,
    input  rail0
  );

endinterface

// File: rtl/ncl_dr_tx_sync2.sv
// rtl/ncl_dr_tx_sync2.sv - two-flop synchronizer for the async ki input
//
// Purpose : brings an asynchronous level into the clk domain (2-cycle latency).
// Ports   : i_clk - clock
//           i_rst - synchronous reset, active-high; both flops clear to 0
//           i_d   - asynchronous input
//           o_q   - synchronized output
module ncl_dr_tx_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ncl_dr_tx.sv
// rtl/ncl_dr_tx.sv - clocked-to-NCL dual-rail transmitter
//
// Purpose : accepts single-rail words on a valid/ready handshake and drives them
//           as DATA/NULL wavefronts into an asynchronous NCL pipeline, paced by
//           the receiver's completion acknowledge ki.
// Ports   : i_clk      - system clock
//           i_rst      - synchronous reset, active-high
//           bus        - ncl_dr_tx_if.slave (in_valid/in_ready/in_data, ki, rail1/rail0)
//           o_busy     - a wavefront is outstanding (state != S_NULL)
//           o_err      - sticky ack-timeout flag, cleared only by reset
//           o_tx_count - completed DATA+NULL cycles, wraps at 2^16
// Params  : WIDTH   - data bits (one rail pair each)
//           TIMEOUT - max cycles waiting on a ki transition; 0 disables the timeout
module ncl_dr_tx
  import ncl_dr_tx_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  ncl_dr_tx_if.slave  bus,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_tx_count
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  state_e           r_state;
  logic [WIDTH-1:0] r_rail1;
  logic [WIDTH-1:0] r_rail0;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_tx_count;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_rail1_nxt;
  logic [WIDTH-1:0] w_rail0_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [15:0]      w_tx_count_nxt;

  logic             w_ki_s;
  logic             w_in_ready;
  logic             w_err;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_timeout;

  ncl_dr_tx_sync2 u_ki_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (bus.ki),
    .o_q   (w_ki_s)
  );

  assign w_err      = (r_state == S_ERR);
  assign w_in_ready = (r_state == S_NULL) && w_ki_s && !w_err;
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_timeout  = (TIMEOUT != 0) && (w_cnt_inc == TO_VAL);

  // Next-state / datapath. The ki_s test precedes the timeout test in each
  // waiting state, so an acknowledge arriving on the timeout cycle still wins.
  always_comb begin
    w_state_nxt    = r_state;
    w_rail1_nxt    = r_rail1;
    w_rail0_nxt    = r_rail0;
    w_cnt_nxt      = r_cnt;
    w_tx_count_nxt = r_tx_count;

    case (r_state)
      S_NULL: begin
        w_rail1_nxt = '0;
        w_rail0_nxt = '0;
        if (bus.in_valid && w_in_ready) begin
          for (int i = 0; i < WIDTH; i++) begin
            {w_rail1_nxt[i], w_rail0_nxt[i]} = dr_encode(bus.in_data[i]);
          end
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end
      end

      S_DATA: begin
        if (!w_ki_s) begin
          w_rail1_nxt = '0;
          w_rail0_nxt = '0;
          w_state_nxt = S_RFD;
          w_cnt_nxt   = '0;
        end else if (w_timeout) begin
          w_rail1_nxt = '0;
          w_rail0_nxt = '0;
          w_state_nxt = S_ERR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_RFD: begin
        w_rail1_nxt = '0;
        w_rail0_nxt = '0;
        if (w_ki_s) begin
          w_tx_count_nxt = r_tx_count + 16'd1;
          w_state_nxt    = S_NULL;
          w_cnt_nxt      = '0;
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_ERR: begin
        w_rail1_nxt = '0;
        w_rail0_nxt = '0;
      end

      default: begin
        w_rail1_nxt = '0;
        w_rail0_nxt = '0;
        w_state_nxt = S_NULL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Rails are driven straight from these flops so every bit of a wavefront
  // switches on the same edge with no glitching logic downstream.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_NULL;
      r_rail1    <= '0;
      r_rail0    <= '0;
      r_cnt      <= '0;
      r_tx_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rail1    <= w_rail1_nxt;
      r_rail0    <= w_rail0_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_count <= w_tx_count_nxt;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.rail1    = r_rail1;
  assign bus.rail0    = r_rail0;
  assign o_busy       = (r_state != S_NULL);
  assign o_err        = w_err;
  assign o_tx_count   = r_tx_count;

endmodule

// File: tb/tb_ncl_dr_tx.sv
// tb/tb_ncl_dr_tx.sv - self-checking bench for ncl_dr_tx
module tb_ncl_dr_tx;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_r1;
    logic [7:0] exp_r0;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        busy;
  logic        err;
  logic [15:0] tx_count;

  logic        ki_manual;
  logic        ki_model = 1'b1;
  logic        model_en;

  int          checks;
  int          failures;

  logic [15:0] sb_q[$];
  logic [15:0] obs_q[$];
  logic        mon_prev_data = 1'b0;
  int          bad11 = 0;

  logic        rx_seen_data = 1'b0;
  int          rx_cd = 0;

  vec_t        vecs[4];

  ncl_dr_tx_if #(.WIDTH(8)) bus ();

  assign bus.ki = model_en ? ki_model : ki_manual;

  ncl_dr_tx #(.WIDTH(8), .TIMEOUT(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_busy     (busy),
    .o_err      (err),
    .o_tx_count (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observes every NULL->DATA wavefront and watches for the illegal 11 code.
  always @(negedge clk) begin
    if (((bus.rail1 | bus.rail0) != 8'h00) && !mon_prev_data)
      obs_q.push_back({bus.rail1, bus.rail0});
    mon_prev_data <= ((bus.rail1 | bus.rail0) != 8'h00);
    if ((bus.rail1 & bus.rail0) != 8'h00)
      bad11 <= bad11 + 1;
  end

  // Model NCL receiver: flips ki three cycles after each rail change.
  always @(negedge clk) begin
    if (!model_en) begin
      rx_cd        <= 0;
      rx_seen_data <= 1'b0;
      ki_model     <= 1'b1;
    end else if (((bus.rail1 | bus.rail0) != 8'h00) != rx_seen_data) begin
      rx_seen_data <= ((bus.rail1 | bus.rail0) != 8'h00);
      rx_cd        <= 3;
    end else if (rx_cd != 0) begin
      rx_cd <= rx_cd - 1;
      if (rx_cd == 1)
        ki_model <= !rx_seen_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic send_word(input logic [7:0] d, input logic [7:0] e1, input logic [7:0] e0);
    logic ok;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    wait_ready(200, ok);
    if (ok) sb_q.push_back({e1, e0});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sb_compare(input string name);
    logic [15:0] e;
    logic [15:0] o;
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs_q.pop_front();
      chk(name, {16'h0, o}, {16'h0, e});
    end
    chk({name, "_leftover_exp"}, sb_q.size(), 0);
    chk({name, "_leftover_obs"}, obs_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  initial begin
    int viol;
    int waited;
    logic ok;

    vecs[0] = '{data: 8'h3C, exp_r1: 8'h3C, exp_r0: 8'hC3};
    vecs[1] = '{data: 8'hFF, exp_r1: 8'hFF, exp_r0: 8'h00};
    vecs[2] = '{data: 8'h00, exp_r1: 8'h00, exp_r0: 8'hFF};
    vecs[3] = '{data: 8'h96, exp_r1: 8'h96, exp_r0: 8'h69};

    checks       = 0;
    failures     = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    ki_manual    = 1'b0;
    model_en     = 1'b0;
    do_reset(3);

    // Reset state, then ki rises: in_ready follows 2 cycles later
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_rail1", bus.rail1, 0);
    chk("rst_rail0", bus.rail0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_txc", tx_count, 0);
    ki_manual = 1'b1;
    tick(1);
    chk("sync_ready_c1", bus.in_ready, 0);
    tick(1);
    chk("sync_ready_c2", bus.in_ready, 1);
    chk("sync_rails", {bus.rail1, bus.rail0}, 0);
    chk("sync_busy", busy, 0);

    // Single word 0xA5 through a full DATA/NULL cycle
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    sb_q.push_back({8'hA5, 8'h5A});
    tick(1);
    bus.in_valid = 1'b0;
    chk("a5_rail1", bus.rail1, 8'hA5);
    chk("a5_rail0", bus.rail0, 8'h5A);
    chk("a5_busy", busy, 1);
    chk("a5_ready", bus.in_ready, 0);
    tick(2);
    ki_manual = 1'b0;
    tick(2);
    chk("a5_hold", {bus.rail1, bus.rail0}, 16'hA55A);
    tick(1);
    chk("a5_null", {bus.rail1, bus.rail0}, 0);
    chk("a5_rfd_busy", busy, 1);
    ki_manual = 1'b1;
    tick(2);
    chk("a5_txc_before", tx_count, 0);
    tick(1);
    chk("a5_txc", tx_count, 1);
    chk("a5_ready_again", bus.in_ready, 1);
    chk("a5_idle", busy, 0);
    sb_compare("a5_sb");

    // Streamed words against the model receiver
    model_en = 1'b1;
    do_reset(2);
    chk("str_txc0", tx_count, 0);
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = vecs[i].data;
      bus.in_valid = 1'b1;
      wait_ready(200, ok);
      if (ok) sb_q.push_back({vecs[i].exp_r1, vecs[i].exp_r0});
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    waited = 0;
    while (tx_count != 16'd4 && waited < 400) begin
      tick(1);
      waited++;
    end
    chk("str_txc", tx_count, 4);
    sb_compare("str_sb");
    ki_manual = 1'b1;
    tick(4);
    model_en = 1'b0;
    tick(1);

    // Reset in the middle of a DATA wavefront
    send_word(8'h81, 8'h81, 8'h7E);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rails", {bus.rail1, bus.rail0}, 0);
    chk("mid_busy_after", busy, 0);
    chk("mid_txc", tx_count, 0);
    chk("mid_err", err, 0);
    sb_compare("mid_sb");

    // ki stuck at 1 after DATA -> timeout after 16 cycles, sticky until reset
    send_word(8'h3C, 8'h3C, 8'hC3);
    tick(15);
    chk("to_err_c15", err, 0);
    chk("to_rail1_c15", bus.rail1, 8'h3C);
    tick(1);
    chk("to_err_c16", err, 1);
    chk("to_rails_c16", {bus.rail1, bus.rail0}, 0);
    chk("to_ready_c16", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    ki_manual    = 1'b0;
    tick(10);
    ki_manual    = 1'b1;
    tick(20);
    chk("to_err_sticky", err, 1);
    chk("to_ready_sticky", bus.in_ready, 0);
    chk("to_rails_sticky", {bus.rail1, bus.rail0}, 0);
    chk("to_txc", tx_count, 0);
    bus.in_valid = 1'b0;
    do_reset(1);
    chk("to_err_cleared", err, 0);
    sb_compare("to_sb");

    // in_valid while ki=0: nothing accepted until ki returns
    ki_manual = 1'b0;
    do_reset(2);
    bus.in_data  = 8'h0F;
    bus.in_valid = 1'b1;
    sb_q.push_back({8'h0F, 8'hF0});
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready || ((bus.rail1 | bus.rail0) != 8'h00)) viol++;
    end
    chk("nki_no_accept", viol, 0);
    @(posedge clk);
    #1;
    ki_manual = 1'b1;
    tick(2);
    chk("nki_ready", bus.in_ready, 1);
    chk("nki_rails_pre", {bus.rail1, bus.rail0}, 0);
    tick(1);
    bus.in_valid = 1'b0;
    chk("nki_rails", {bus.rail1, bus.rail0}, 16'h0FF0);
    tick(1);
    sb_compare("nki_sb");
    chk("no_11_pairs", bad11, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
